lm_sm_sequencer: RTL
====================

# lm_sm_sequencer

Multi-register transfer sequencer for the load-multiple (LM) and store-multiple (SM) instructions. On a start pulse it walks an 8-bit register mask one register per cycle, issuing register-file addresses and write strobes and memory addresses and strobes for consecutive words from a base address. It sits directly upstream of the 8 x 16-bit register file. It drives the register file's write destination and write enable (LM) or read address (SM), and stalls the front end while it runs.

## Interface
- AW, 16, memory address width; also the width of the base-register writeback value.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a sequence; sampled only in IDLE.
- is_load  input  1  1 = LM (memory -> regs), 0 = SM (regs -> memory); latched on start.
- reg_mask  input  8  bit i set = transfer register Ri; latched on start.
- base_addr  input  AW  address of the first word; latched on start.
- base_reg  input  3  index of the base register, used by writeback; latched on start.
- hold  input  1  downstream/memory not ready; freezes the sequence.
- busy  output  1  sequence in progress (XFER or WB state).
- done  output  1  one-cycle completion pulse.
- rf_addr  output  3  register index: write destination for LM, read address for SM.
- rf_we  output  1  register-file write enable.
- mem_addr  output  AW  memory word address.
- mem_re  output  1  memory read strobe (LM).
- mem_we  output  1  memory write strobe (SM).

## Operation
- States: IDLE, XFER, WB, DONE. WB exists only with the configuration macro defined.
- IDLE, start=1: latch the inputs and clear the offset counter (4 bits, 0..8).
  - reg_mask != 0 -> XFER.
  - reg_mask == 0 -> DONE; no transfers and no writeback.
- start is ignored outside IDLE.
- XFER:
  - rf_addr = index of the lowest set bit of the remaining mask, so registers go in ascending order R0..R7.
  - mem_addr = latched base + offset, modulo 2^AW (wraps 0xFFFF -> 0x0000).
- Each XFER cycle with hold=0:
  - LM: mem_re=1, rf_we=1; the register file captures memory read data on this edge.
  - SM: mem_we=1; memory captures the register-file read data.
  - Clear the serviced mask bit and increment the offset.
  - If the remaining mask becomes 0 -> WB (macro defined) or DONE.
- XFER with hold=1: rf_we, mem_re and mem_we forced to 0. Mask, offset, rf_addr and mem_addr hold their values.
- WB: rf_addr = base_reg, rf_we=1, with write data = base + transfer count (exposed as an additional output wb_data[AW-1:0]).
  - Applies to both LM and SM.
  - Stalls on hold exactly as XFER does.
  - Goes to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- LM with base_reg in the mask: the WB write is last, so the base register ends with the writeback value.
- rf_addr, mem_addr and the strobes are decoded from registered state plus hold only; there is no combinational path from start.

## Timing
- Reset values: busy=0, done=0, rf_addr=0, rf_we=0, mem_addr=0, mem_re=0, mem_we=0, wb_data=0. State goes to IDLE and the mask clears.
- rst asserted mid-sequence: immediate abort, all outputs to reset values, no done pulse.
- start sampled at edge 0 with N set bits and no hold:
  - transfers occur in cycles 1..N;
  - WB in cycle N+1 (macro defined);
  - done in cycle N+2 (macro defined) or N+1 (macro not defined).
- Every cycle with hold=1 during XFER or WB delays completion by exactly one cycle.
- Empty mask: done in cycle 1, busy never asserts.
- Throughput: one register per cycle; maximum 8 transfers. Back-to-back start is accepted in the cycle after done.

## Configuration
- LMSM_BASE_WRITEBACK_EN defined: the WB state and the wb_data output are present, and the base register is updated to base + popcount(mask).
- LMSM_BASE_WRITEBACK_EN not defined: no WB state. wb_data is tied to 0 and the base register is never written. Sequences end one cycle earlier.

## Test plan
- Reset, then LM with mask=0x15 (bits 0, 2, 4), base=0x0100, hold=0 -> rf_addr 0,2,4 and mem_addr 0x0100,0x0101,0x0102 in cycles 1-3, with rf_we=mem_re=1. With macro: WB writes 0x0103 to base_reg in cycle 4 and done in cycle 5.
- SM with mask=0x80, base=0xFFFF -> one transfer, rf_addr=7, mem_addr=0xFFFF, mem_we=1. With macro: WB value 0x0000 (wrap).
- LM with mask=0xFF and hold=1 for cycles 3-4 -> strobes low and addresses frozen while held. Done arrives 2 cycles late; all 8 registers are written exactly once.
- start with mask=0x00 -> done in cycle 1, busy never high, no strobes.
- LM with mask=0x0F, rst asserted during the third transfer -> outputs to 0 immediately and state IDLE. A fresh start afterwards runs a full, correct sequence.
- start pulsed again during a running sequence -> ignored; the sequence completes unchanged.

Source files
------------

// File: rtl/lm_sm_sequencer_if.sv
// Bundle between the front end and the LM/SM sequencer: instruction launch
// fields and hold coming in, register-file/memory strobes and status going out.
// master = front end / pipeline side, slave = lm_sm_sequencer.
interface lm_sm_sequencer_if #(
    parameter int AW = 16
);
    logic          start;
    logic          is_load;
    logic [7:0]    reg_mask;
    logic [AW-1:0] base_addr;
    logic [2:0]    base_reg;
    logic          hold;

    logic          busy;
    logic          done;
    logic [2:0]    rf_addr;
    logic          rf_we;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] wb_data;

    modport master (
        output start, is_load, reg_mask, base_addr, base_reg, hold,
        input  busy, done, rf_addr, rf_we, mem_addr, mem_re, mem_we, wb_data
    );

    modport slave (
        input  start, is_load, reg_mask, base_addr, base_reg, hold,
        output busy, done, rf_addr, rf_we, mem_addr, mem_re, mem_we, wb_data
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer. Walks an 8-bit register mask in
// ascending order, one register per un-held cycle, pairing each register with
// consecutive memory words starting at the latched base address.
// Optional feature macro: LMSM_BASE_WRITEBACK_EN adds a WB state that writes
// base + transfer count back to the base register and drives wb_data; without
// it wb_data is tied to zero and sequences end one cycle earlier.
// All outputs decode from registered state plus hold, never from start.
module lm_sm_sequencer #(
    parameter int AW = 16
) (
    input logic              clk,
    input logic              rst,
    lm_sm_sequencer_if.slave bus
);

`ifdef LMSM_BASE_WRITEBACK_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd3
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [7:0]    mask_q, mask_d;      // registers still to transfer
    logic [3:0]    off_q, off_d;        // words transferred so far, 0..8
    logic [AW-1:0] base_q, base_d;
    logic          is_load_q, is_load_d;
`ifdef LMSM_BASE_WRITEBACK_EN
    logic [2:0]    base_reg_q, base_reg_d;
`endif
    logic [7:0]    mask_clr;

    // Index of the lowest set bit; zero for an empty mask (never decoded then).
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Control state: aborts immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= 8'd0;
            off_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            off_q   <= off_d;
        end
    end

    // Latched instruction fields; only observed while a sequence is active.
    always_ff @(posedge clk) begin
        base_q    <= base_d;
        is_load_q <= is_load_d;
`ifdef LMSM_BASE_WRITEBACK_EN
        base_reg_q <= base_reg_d;
`endif
    end

    // Next-state: launch on start in IDLE, retire one mask bit per un-held XFER cycle.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        off_d     = off_q;
        base_d    = base_q;
        is_load_d = is_load_q;
`ifdef LMSM_BASE_WRITEBACK_EN
        base_reg_d = base_reg_q;
`endif
        // Clearing the lowest set bit is exactly the register being serviced.
        mask_clr  = mask_q & (mask_q - 8'd1);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mask_d    = bus.reg_mask;
                    off_d     = 4'd0;
                    base_d    = bus.base_addr;
                    is_load_d = bus.is_load;
`ifdef LMSM_BASE_WRITEBACK_EN
                    base_reg_d = bus.base_reg;
`endif
                    // An empty mask skips transfers and writeback entirely.
                    state_d = (bus.reg_mask != 8'd0) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                if (!bus.hold) begin
                    mask_d = mask_clr;
                    off_d  = off_q + 4'd1;
                    if (mask_clr == 8'd0) begin
`ifdef LMSM_BASE_WRITEBACK_EN
                        state_d = ST_WB;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef LMSM_BASE_WRITEBACK_EN
            ST_WB: begin
                if (!bus.hold) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: addresses stay visible under hold, strobes drop.
    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.rf_addr  = 3'd0;
        bus.rf_we    = 1'b0;
        bus.mem_addr = '0;
        bus.mem_re   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.wb_data  = '0;

        case (state_q)
            ST_XFER: begin
                bus.busy     = 1'b1;
                bus.rf_addr  = lowest_set(mask_q);
                // Wraps modulo 2^AW by construction of the adder width.
                bus.mem_addr = base_q + AW'(off_q);
                bus.rf_we    = is_load_q && !bus.hold;
                bus.mem_re   = is_load_q && !bus.hold;
                bus.mem_we   = !is_load_q && !bus.hold;
            end
`ifdef LMSM_BASE_WRITEBACK_EN
            ST_WB: begin
                bus.busy    = 1'b1;
                bus.rf_addr = base_reg_q;
                bus.rf_we   = !bus.hold;
                // off_q now equals popcount of the launched mask.
                bus.wb_data = base_q + AW'(off_q);
            end
`endif
            ST_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
